// File: rtl/load_store_pkg.sv
// Shared types for the load/store unit: FSM states, funct3 size codes, size decode.
// Pure declarations; no latency or backpressure of its own.
package load_store_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ_LO,
    READ_HI,
    WRITE_LO,
    WRITE_HI,
    RESPOND
  } state_t;

  localparam logic [1:0] SIZE_BYTE   = 2'd0;
  localparam logic [1:0] SIZE_HALF   = 2'd1;
  localparam logic [1:0] SIZE_WORD   = 2'd2;
  localparam logic [1:0] SIZE_DOUBLE = 2'd3;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response and RAM port bundle; slave = the unit, master = core plus RAM.
// Valid/ready on both sides; RAM read data is valid in the handshake cycle.
interface load_store_unit_if #(parameter int XLEN = 64);
  logic            req_valid;
  logic            req_ready;
  logic            req_store;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_address;
  logic [XLEN-1:0] req_store_value;
  logic            resp_valid;
  logic            resp_efault;
  logic [XLEN-1:0] resp_load_value;
  logic            ram_valid;
  logic            ram_ready;
  logic            ram_write;
  logic [XLEN-1:0] ram_address;
  logic [XLEN-1:0] ram_store_value;
  logic [XLEN-1:0] ram_load_value;

  modport slave (
    input  req_valid, req_store, req_funct3, req_address, req_store_value,
    input  ram_ready, ram_load_value,
    output req_ready, resp_valid, resp_efault, resp_load_value,
    output ram_valid, ram_write, ram_address, ram_store_value
  );

  modport master (
    output req_valid, req_store, req_funct3, req_address, req_store_value,
    output ram_ready, ram_load_value,
    input  req_ready, resp_valid, resp_efault, resp_load_value,
    input  ram_valid, ram_write, ram_address, ram_store_value
  );
endinterface

// File: rtl/load_store_align.sv
// Combinational byte lane logic: load extraction/extension, store merge into {hi,lo}, cross flag.
// Zero latency, no backpressure.
module load_store_align
  import load_store_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int OFFW = $clog2(XLEN / 8)
) (
  input  logic [OFFW-1:0] i_offset,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_store_value,
  output logic [XLEN-1:0] o_load_value,
  output logic [XLEN-1:0] o_store_lo,
  output logic [XLEN-1:0] o_store_hi,
  output logic            o_cross
);
  localparam int WORD = XLEN / 8;

  logic [3:0]        w_size;
  logic [4:0]        w_end;
  logic [2*XLEN-1:0] w_pair;
  logic [XLEN-1:0]   w_shift;
  logic [2*XLEN-1:0] w_sdata;
  logic [2*XLEN-1:0] w_rdata;
  logic [2*XLEN-1:0] w_merged;
  logic              w_sign;
  logic              w_ext;

  always_comb begin
    w_size       = size_bytes(i_funct3);
    w_end        = {1'b0, w_size} + 5'(i_offset);
    o_cross      = w_end > 5'(WORD);
    w_pair       = {(o_cross ? i_hi : {XLEN{1'b0}}), i_lo};
    w_shift      = XLEN'(w_pair >> {i_offset, 3'b000});
    w_sign       = 1'b0;
    o_load_value = '0;

    // Faulting sizes never reach here meaningfully, so DOUBLE falls back to the top bit.
    case (i_funct3[1:0])
      SIZE_BYTE: w_sign = w_shift[7];
      SIZE_HALF: w_sign = w_shift[15];
      SIZE_WORD: w_sign = w_shift[31];
      default:   w_sign = w_shift[XLEN-1];
    endcase
    w_ext = w_sign & ~i_funct3[2];

    for (int i = 0; i < WORD; i++) begin
      o_load_value[i*8 +: 8] = (i < int'(w_size)) ? w_shift[i*8 +: 8] : {8{w_ext}};
    end

    w_sdata  = {{XLEN{1'b0}}, i_store_value} << {i_offset, 3'b000};
    w_rdata  = {i_hi, i_lo};
    w_merged = w_rdata;
    for (int j = 0; j < 2 * WORD; j++) begin
      if (j >= int'(i_offset) && j < int'(w_end)) begin
        w_merged[j*8 +: 8] = w_sdata[j*8 +: 8];
      end
    end
    o_store_lo = w_merged[XLEN-1:0];
    o_store_hi = w_merged[2*XLEN-1:XLEN];
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one transaction at a time, word-crossing accesses split in two, sub-word stores via RMW.
// Latency 1 (fault) to 5 cycles plus RAM stalls; req_ready only in IDLE, RAM side holds ram_* while stalled.
module load_store_unit
  import load_store_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  load_store_unit_if.slave   bus
);
  localparam int WORD = XLEN / 8;
  localparam int OFFW = $clog2(WORD);

  state_t          r_state;
  state_t          w_next;
  logic            r_store;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_address;
  logic [XLEN-1:0] r_store_value;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_hi;
  logic            r_resp_valid;
  logic            r_resp_efault;
  logic [XLEN-1:0] r_resp_load_value;

  logic [3:0]      w_req_size;
  logic            w_req_fault;
  logic            w_req_fire;
  logic            w_cross;
  logic [XLEN-1:0] w_lo;
  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_load_value;
  logic [XLEN-1:0] w_store_lo;
  logic [XLEN-1:0] w_store_hi;
  logic [XLEN-1:0] w_lo_addr;
  logic [XLEN-1:0] w_hi_addr;

  assign w_req_size  = size_bytes(bus.req_funct3);
  assign w_req_fault = (w_req_size > 4'(WORD)) ||
                       ((w_req_size == 4'(WORD)) && bus.req_funct3[2]);
  assign w_req_fire  = (r_state == IDLE) && bus.req_valid;

  assign w_lo_addr = {r_address[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign w_hi_addr = w_lo_addr + XLEN'(WORD);

  // Read data is consumed in its handshake cycle so the response can be registered on entry to RESPOND.
  assign w_lo = (r_state == READ_LO) ? bus.ram_load_value : r_lo;
  assign w_hi = (r_state == READ_HI) ? bus.ram_load_value : r_hi;

  load_store_align #(.XLEN(XLEN)) u_align (
    .i_offset      (r_address[OFFW-1:0]),
    .i_funct3      (r_funct3),
    .i_lo          (w_lo),
    .i_hi          (w_hi),
    .i_store_value (r_store_value),
    .o_load_value  (w_load_value),
    .o_store_lo    (w_store_lo),
    .o_store_hi    (w_store_hi),
    .o_cross       (w_cross)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next              = r_state;
    bus.req_ready       = 1'b0;
    bus.ram_valid       = 1'b0;
    bus.ram_write       = 1'b0;
    bus.ram_address     = '0;
    bus.ram_store_value = '0;
    case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          w_next = w_req_fault ? RESPOND : READ_LO;
        end
      end
      READ_LO: begin
        bus.ram_valid   = 1'b1;
        bus.ram_address = w_lo_addr;
        if (bus.ram_ready) begin
          w_next = w_cross ? READ_HI : (r_store ? WRITE_LO : RESPOND);
        end
      end
      READ_HI: begin
        bus.ram_valid   = 1'b1;
        bus.ram_address = w_hi_addr;
        if (bus.ram_ready) begin
          w_next = r_store ? WRITE_LO : RESPOND;
        end
      end
      WRITE_LO: begin
        bus.ram_valid       = 1'b1;
        bus.ram_write       = 1'b1;
        bus.ram_address     = w_lo_addr;
        bus.ram_store_value = w_store_lo;
        if (bus.ram_ready) begin
          w_next = w_cross ? WRITE_HI : RESPOND;
        end
      end
      WRITE_HI: begin
        bus.ram_valid       = 1'b1;
        bus.ram_write       = 1'b1;
        bus.ram_address     = w_hi_addr;
        bus.ram_store_value = w_store_hi;
        if (bus.ram_ready) begin
          w_next = RESPOND;
        end
      end
      RESPOND: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_store           <= 1'b0;
      r_funct3          <= '0;
      r_address         <= '0;
      r_store_value     <= '0;
      r_lo              <= '0;
      r_hi              <= '0;
      r_resp_valid      <= 1'b0;
      r_resp_efault     <= 1'b0;
      r_resp_load_value <= '0;
    end else begin
      if (w_req_fire) begin
        r_store       <= bus.req_store;
        r_funct3      <= bus.req_funct3;
        r_address     <= bus.req_address;
        r_store_value <= bus.req_store_value;
        r_lo          <= '0;
        r_hi          <= '0;
      end
      if (r_state == READ_LO && bus.ram_ready) r_lo <= bus.ram_load_value;
      if (r_state == READ_HI && bus.ram_ready) r_hi <= bus.ram_load_value;
      r_resp_valid      <= (w_next == RESPOND);
      r_resp_efault     <= w_req_fire && w_req_fault;
      r_resp_load_value <= (w_next == RESPOND && r_state != IDLE && r_state != RESPOND && !r_store)
                           ? w_load_value : '0;
    end
  end

  assign bus.resp_valid      = r_resp_valid;
  assign bus.resp_efault     = r_resp_efault;
  assign bus.resp_load_value = r_resp_load_value;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (XLEN=64) with a word RAM model and response/RAM-access scoreboards.
module tb_load_store_unit;
  localparam int XLEN = 64;

  typedef struct {
    logic        ef;
    logic [63:0] val;
    int          lat;
  } resp_t;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] dat;
  } ram_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  logic ram_rdy = 1'b1;

  logic [63:0] mem [4] = '{64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0, 64'h0};

  resp_t resp_q[$];
  ram_t  ram_q[$];

  int n_checks   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int h_cyc      = 0;
  int resp_count = 0;
  int n_exp      = 0;

  always #5 clock = ~clock;

  load_store_unit_if #(.XLEN(XLEN)) dut_if ();

  load_store_unit #(.XLEN(XLEN)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (dut_if)
  );

  assign dut_if.ram_ready      = ram_rdy;
  assign dut_if.ram_load_value = mem[dut_if.ram_address[4:3]];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (dut_if.ram_valid && dut_if.ram_ready && dut_if.ram_write)
      mem[dut_if.ram_address[4:3]] <= dut_if.ram_store_value;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin : monitor
    ram_t  e;
    resp_t r;
    if (reset_n) begin
      if (dut_if.ram_valid && dut_if.ram_ready) begin
        check("ram_access_expected", 64'(ram_q.size() > 0), 64'd1);
        if (ram_q.size() > 0) begin
          e = ram_q.pop_front();
          check("ram_write_flag", 64'(dut_if.ram_write), 64'(e.wr));
          check("ram_address", dut_if.ram_address, e.addr);
          if (e.wr) check("ram_store_value", dut_if.ram_store_value, e.dat);
        end
      end
      if (dut_if.resp_valid) begin
        check("resp_expected", 64'(resp_q.size() > 0), 64'd1);
        if (resp_q.size() > 0) begin
          r = resp_q.pop_front();
          check("resp_efault", 64'(dut_if.resp_efault), 64'(r.ef));
          check("resp_load_value", dut_if.resp_load_value, r.val);
          check("resp_latency", 64'(cyc - h_cyc + 1), 64'(r.lat));
        end
        resp_count++;
      end
    end
  end

  task automatic exp_ram(input logic wr, input logic [63:0] addr, input logic [63:0] dat);
    ram_t e;
    e.wr = wr; e.addr = addr; e.dat = dat;
    ram_q.push_back(e);
  endtask

  task automatic exp_resp(input logic ef, input logic [63:0] val, input int lat);
    resp_t r;
    r.ef = ef; r.val = val; r.lat = lat;
    resp_q.push_back(r);
    n_exp++;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] val);
    @(negedge clock);
    check("req_ready_idle", 64'(dut_if.req_ready), 64'd1);
    dut_if.req_valid       = 1'b1;
    dut_if.req_store       = st;
    dut_if.req_funct3      = f3;
    dut_if.req_address     = addr;
    dut_if.req_store_value = val;
    @(posedge clock);
    #1;
    h_cyc = cyc;
    dut_if.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    for (int i = 0; i < 40 && resp_count < target; i++) @(posedge clock);
    check("resp_timeout", 64'(resp_count >= target), 64'd1);
  endtask

  task automatic txn(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                     input logic [63:0] val, input logic ef, input logic [63:0] lv, input int lat);
    exp_resp(ef, lv, lat);
    issue(st, f3, addr, val);
    wait_resp(n_exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"}, 64'(dut_if.req_ready), 64'd1);
    check({tag, "_resp_valid"}, 64'(dut_if.resp_valid), 64'd0);
    check({tag, "_resp_efault"}, 64'(dut_if.resp_efault), 64'd0);
    check({tag, "_resp_load_value"}, dut_if.resp_load_value, 64'd0);
    check({tag, "_ram_valid"}, 64'(dut_if.ram_valid), 64'd0);
    check({tag, "_ram_write"}, 64'(dut_if.ram_write), 64'd0);
    check({tag, "_ram_address"}, dut_if.ram_address, 64'd0);
    check({tag, "_ram_store_value"}, dut_if.ram_store_value, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dut_if.req_valid       = 1'b0;
    dut_if.req_store       = 1'b0;
    dut_if.req_funct3      = 3'd0;
    dut_if.req_address     = 64'd0;
    dut_if.req_store_value = 64'd0;
    #2 reset_n = 1'b0;
    #10;
    check_reset("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Loads against the initial RAM image.
    exp_ram(0, 64'h0, 0);
    txn(0, 3'd0, 64'h0, 0, 0, 64'hffffffffffffffef, 2);
    exp_ram(0, 64'h0, 0); exp_ram(0, 64'h8, 0);
    txn(0, 3'd2, 64'h6, 0, 0, 64'h0000000032100123, 3);
    exp_ram(0, 64'h0, 0); exp_ram(0, 64'h8, 0);
    txn(0, 3'd1, 64'h7, 0, 0, 64'h0000000000001001, 3);
    exp_ram(0, 64'h0, 0);
    txn(0, 3'd5, 64'h2, 0, 0, 64'h00000000000089ab, 2);
    exp_ram(0, 64'h0, 0);
    txn(0, 3'd3, 64'h0, 0, 0, 64'h0123456789abcdef, 2);
    exp_ram(0, 64'h8, 0);
    txn(0, 3'd4, 64'hf, 0, 0, 64'h00000000000000fe, 2);
    exp_ram(0, 64'h0, 0);
    txn(0, 3'd6, 64'h4, 0, 0, 64'h0000000001234567, 2);

    // Illegal funct3: no RAM traffic, immediate fault response.
    txn(0, 3'd7, 64'h0, 0, 1, 64'h0, 1);

    // Crossing doubleword store, then sub-word store, then a crossing load of the result.
    exp_ram(0, 64'h0, 0); exp_ram(0, 64'h8, 0);
    exp_ram(1, 64'h0, 64'hffffffff89abcdef); exp_ram(1, 64'h8, 64'hfedcba98ffffffff);
    txn(1, 3'd3, 64'h4, 64'hffffffffffffffff, 0, 64'h0, 5);
    exp_ram(0, 64'h0, 0); exp_ram(1, 64'h0, 64'hffffffff89ab5aef);
    txn(1, 3'd0, 64'h1, 64'h000000000000005a, 0, 64'h0, 3);
    exp_ram(0, 64'h0, 0); exp_ram(0, 64'h8, 0);
    txn(0, 3'd1, 64'h7, 0, 0, 64'hffffffffffffffff, 3);

    // Crossing halfword store with three RAM stall cycles in READ_HI.
    exp_ram(0, 64'h0, 0); exp_ram(0, 64'h8, 0);
    exp_ram(1, 64'h0, 64'hefffffff89ab5aef); exp_ram(1, 64'h8, 64'hfedcba98ffffffbe);
    exp_resp(0, 64'h0, 8);
    issue(1, 3'd1, 64'h7, 64'h000000000000beef);
    @(posedge clock);
    #1 ram_rdy = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("stall_ram_valid", 64'(dut_if.ram_valid), 64'd1);
      check("stall_ram_write", 64'(dut_if.ram_write), 64'd0);
      check("stall_ram_address", dut_if.ram_address, 64'h8);
    end
    @(posedge clock);
    #1 ram_rdy = 1'b1;
    wait_resp(n_exp);

    // Same store aborted by reset right after the WRITE_LO handshake.
    exp_ram(0, 64'h0, 0); exp_ram(0, 64'h8, 0);
    exp_ram(1, 64'h0, 64'h34ffffff89ab5aef);
    issue(1, 3'd1, 64'h7, 64'h0000000000001234);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check_reset("midreset");
    @(negedge clock);
    check("midreset_hold_ram_valid", 64'(dut_if.ram_valid), 64'd0);
    check("torn_lo_word", mem[0], 64'h34ffffff89ab5aef);
    check("torn_hi_word", mem[1], 64'hfedcba98ffffffbe);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    check("no_resp_after_reset", 64'(resp_count), 64'(n_exp));

    // Recovery after reset.
    exp_ram(0, 64'h8, 0);
    txn(0, 3'd3, 64'h8, 0, 0, 64'hfedcba98ffffffbe, 2);
    exp_ram(0, 64'h0, 0);
    txn(0, 3'd3, 64'h0, 0, 0, 64'h34ffffff89ab5aef, 2);

    repeat (2) @(posedge clock);
    check("ram_queue_drained", 64'(ram_q.size()), 64'd0);
    check("resp_queue_drained", 64'(resp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
